// File: rtl/axi_node_resp_pkg.sv
// axi_node_resp_pkg: shared B/R response codes and the response payload type of the AXI node
package axi_node_resp_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int B_ID_W = 6;

    typedef struct packed {
        logic [B_ID_W-1:0] id;
        logic [1:0]        resp;
    } b_payload_t;
endpackage

// File: rtl/axi_rr_arb_n.sv
// axi_rr_arb_n: N-input round-robin arbiter, one-hot grant, pointer moves past the winner on grant
module axi_rr_arb_n #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PW = N > 1 ? $clog2(N) : 1;

    logic [PW-1:0] ptr, win;
    logic          found;

    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                win   = PW'((int'(ptr) + i) % N);
            end
        end
        gnt = (en && found) ? N'(1) << win : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (en && found)
            ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
endmodule

// File: rtl/axi_write_resp_allocator.sv
// axi_write_resp_allocator: merges per-port B responses and local DECERRs into one registered B channel
// and tracks outstanding writes for the AW decoder.
module axi_write_resp_allocator
    import axi_node_resp_pkg::*;
#(
    parameter int N_INIT_PORT     = 8,
    parameter int AXI_ID_OUT      = 6,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_INIT_PORT-1:0]                bvalid_i,
    input  logic [N_INIT_PORT-1:0][AXI_ID_OUT-1:0] bid_i,
    input  logic [N_INIT_PORT-1:0][1:0]           bresp_i,
    output logic [N_INIT_PORT-1:0]                bready_o,
    output logic                                  bvalid_o,
    output logic [AXI_ID_OUT-1:0]                 bid_o,
    output logic [1:0]                            bresp_o,
    input  logic                                  bready_i,
    input  logic                                  error_req_i,
    input  logic [AXI_ID_OUT-1:0]                 error_id_i,
    output logic                                  error_gnt_o,
    input  logic                                  incr_req_i,
    output logic                                  full_counter_o,
    output logic                                  outstanding_trans_o
);
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    logic                 load, is_err, inc, dec;
    logic [CNT_WIDTH-1:0] cnt;
    b_payload_t           sel, slot;

    assign load        = ~bvalid_o | bready_i;
    assign error_gnt_o = load & error_req_i;

    axi_rr_arb_n #(.N(N_INIT_PORT)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load & ~error_req_i),
        .req   (bvalid_i),
        .gnt   (bready_o)
    );

    always_comb begin
        sel = error_gnt_o ? '{id: error_id_i, resp: RESP_DECERR} : '0;
        for (int k = 0; k < N_INIT_PORT; k++)
            if (bready_o[k]) sel = '{id: bid_i[k], resp: bresp_i[k]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid_o <= 1'b0;
            slot     <= '0;
            is_err   <= 1'b0;
        end else if (load) begin
            bvalid_o <= error_gnt_o | (|bready_o);
            slot     <= sel;
            is_err   <= error_gnt_o;
        end
    end

    assign bid_o   = slot.id;
    assign bresp_o = slot.resp;

    // DECERRs were never counted in, so they must not count out
    assign inc = incr_req_i;
    assign dec = bvalid_o & bready_i & ~is_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (inc && !dec && !full_counter_o) ? cnt + 1'b1 :
                   (dec && !inc && outstanding_trans_o) ? cnt - 1'b1 : cnt;
    end

    assign full_counter_o      = cnt == CNT_WIDTH'(MAX_OUTSTANDING);
    assign outstanding_trans_o = |cnt;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(inc && !dec && full_counter_o))
        else $error("outstanding counter overflow");
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(dec && !inc && !outstanding_trans_o))
        else $error("outstanding counter underflow");
`endif
endmodule

// File: tb/tb_axi_write_resp_allocator.sv
// tb_axi_write_resp_allocator: directed vectors with hand-computed expectations for the B allocator
module tb_axi_write_resp_allocator;
    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0]      bvalid_i;
    logic [7:0][5:0] bid_i;
    logic [7:0][1:0] bresp_i;
    logic [7:0]      bready_o;
    logic            bvalid_o;
    logic [5:0]      bid_o;
    logic [1:0]      bresp_o;
    logic            bready_i;
    logic            error_req_i;
    logic [5:0]      error_id_i;
    logic            error_gnt_o;
    logic            incr_req_i;
    logic            full_counter_o;
    logic            outstanding_trans_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_write_resp_allocator dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bvalid_i            (bvalid_i),
        .bid_i               (bid_i),
        .bresp_i             (bresp_i),
        .bready_o            (bready_o),
        .bvalid_o            (bvalid_o),
        .bid_o               (bid_o),
        .bresp_o             (bresp_o),
        .bready_i            (bready_i),
        .error_req_i         (error_req_i),
        .error_id_i          (error_id_i),
        .error_gnt_o         (error_gnt_o),
        .incr_req_i          (incr_req_i),
        .full_counter_o      (full_counter_o),
        .outstanding_trans_o (outstanding_trans_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic incr(input int n);
        repeat (n) begin
            @(negedge clk);
            incr_req_i = 1'b1;
        end
        @(negedge clk);
        incr_req_i = 1'b0;
    endtask

    logic [7:0] rr_gnt [4] = '{8'h01, 8'h02, 8'h08, 8'h01};
    logic [5:0] rr_id  [4] = '{6'h10, 6'h11, 6'h13, 6'h10};
    logic [1:0] rr_rsp [4] = '{2'b00, 2'b01, 2'b10, 2'b00};

    initial begin
        rst_n = 1'b0; bvalid_i = '0; bid_i = '0; bresp_i = '0;
        bready_i = 1'b0; error_req_i = 1'b0; error_id_i = '0; incr_req_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bvalid", 32'(bvalid_o), 32'h0);
        check("rst_bid", 32'(bid_o), 32'h0);
        check("rst_bresp", 32'(bresp_o), 32'h0);
        check("rst_outstanding", 32'(outstanding_trans_o), 32'h0);
        check("rst_full", 32'(full_counter_o), 32'h0);
        check("rst_bready", 32'(bready_o), 32'h0);
        check("rst_error_gnt", 32'(error_gnt_o), 32'h0);
        rst_n = 1'b1;

        // round-robin from pointer 0 over ports 0,1,3
        incr(4);
        bid_i[0] = 6'h10; bresp_i[0] = 2'b00;
        bid_i[1] = 6'h11; bresp_i[1] = 2'b01;
        bid_i[3] = 6'h13; bresp_i[3] = 2'b10;
        bvalid_i = 8'h0B; bready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("rr_gnt%0d", i), 32'(bready_o), 32'(rr_gnt[i]));
            if (i > 0) begin
                check($sformatf("rr_bid%0d", i - 1), 32'(bid_o), 32'(rr_id[i-1]));
                check($sformatf("rr_bresp%0d", i - 1), 32'(bresp_o), 32'(rr_rsp[i-1]));
                check($sformatf("rr_bvalid%0d", i - 1), 32'(bvalid_o), 32'h1);
            end
        end
        @(negedge clk);
        bvalid_i = '0;
        check("rr_bid3", 32'(bid_o), 32'(rr_id[3]));
        check("rr_bvalid3", 32'(bvalid_o), 32'h1);
        @(negedge clk);
        check("rr_drained_bvalid", 32'(bvalid_o), 32'h0);
        check("rr_drained_outstanding", 32'(outstanding_trans_o), 32'h0);

        // single port
        incr(1);
        bvalid_i = 8'h04; bid_i[2] = 6'h05; bresp_i[2] = 2'b00;
        #1 check("single_bready", 32'(bready_o), 32'h04);
        @(negedge clk);
        bvalid_i = '0;
        check("single_bvalid", 32'(bvalid_o), 32'h1);
        check("single_bid", 32'(bid_o), 32'h05);
        check("single_bresp", 32'(bresp_o), 32'h0);
        @(negedge clk);
        check("single_outstanding", 32'(outstanding_trans_o), 32'h0);

        // backpressure: port 2 loaded, port 1 waits behind a stalled slice
        incr(2);
        bready_i = 1'b0;
        bvalid_i = 8'h04; bid_i[2] = 6'h07; bresp_i[2] = 2'b10;
        @(negedge clk);
        bvalid_i = 8'h02; bid_i[1] = 6'h11; bresp_i[1] = 2'b01;
        check("bp_bvalid", 32'(bvalid_o), 32'h1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_bready%0d", i), 32'(bready_o), 32'h0);
            check($sformatf("bp_bid%0d", i), 32'(bid_o), 32'h07);
            check($sformatf("bp_bresp%0d", i), 32'(bresp_o), 32'h2);
            @(negedge clk);
        end
        bready_i = 1'b1;
        #1 check("bp_release_bready", 32'(bready_o), 32'h02);
        @(negedge clk);
        bvalid_i = '0;
        check("bp_next_bid", 32'(bid_o), 32'h11);
        check("bp_next_bresp", 32'(bresp_o), 32'h1);
        @(negedge clk);
        check("bp_outstanding", 32'(outstanding_trans_o), 32'h0);

        // counter fill, simultaneous inc/dec, drain
        incr(8);
        check("cnt_full", 32'(full_counter_o), 32'h1);
        check("cnt_outstanding", 32'(outstanding_trans_o), 32'h1);
        bvalid_i = 8'h01; bid_i[0] = 6'h20; bresp_i[0] = 2'b00;
        @(negedge clk);
        bvalid_i = '0; incr_req_i = 1'b1;
        check("cnt_hs_bvalid", 32'(bvalid_o), 32'h1);
        @(negedge clk);
        incr_req_i = 1'b0;
        check("cnt_incdec_full", 32'(full_counter_o), 32'h1);
        bvalid_i = 8'h01;
        repeat (8) @(negedge clk);
        bvalid_i = '0;
        check("cnt_draining_full", 32'(full_counter_o), 32'h0);
        check("cnt_draining_outstanding", 32'(outstanding_trans_o), 32'h1);
        @(negedge clk);
        check("cnt_drained_outstanding", 32'(outstanding_trans_o), 32'h0);
        check("cnt_drained_bvalid", 32'(bvalid_o), 32'h0);

        // DECERR beats a coincident port request
        error_req_i = 1'b1; error_id_i = 6'h2A; bvalid_i = 8'h01;
        #1;
        check("err_gnt", 32'(error_gnt_o), 32'h1);
        check("err_bready", 32'(bready_o), 32'h0);
        @(negedge clk);
        error_req_i = 1'b0; bvalid_i = '0;
        check("err_bvalid", 32'(bvalid_o), 32'h1);
        check("err_bid", 32'(bid_o), 32'h2A);
        check("err_bresp", 32'(bresp_o), 32'h3);
        @(negedge clk);
        check("err_outstanding", 32'(outstanding_trans_o), 32'h0);
        check("err_done_bvalid", 32'(bvalid_o), 32'h0);

        // reset while a response is held
        incr(3);
        bready_i = 1'b0; bvalid_i = 8'h01;
        @(negedge clk);
        bvalid_i = '0;
        check("mrst_pre_bvalid", 32'(bvalid_o), 32'h1);
        check("mrst_pre_outstanding", 32'(outstanding_trans_o), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_bvalid", 32'(bvalid_o), 32'h0);
        check("mrst_outstanding", 32'(outstanding_trans_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; bready_i = 1'b1;
        @(negedge clk);
        check("mrst_after_outstanding", 32'(outstanding_trans_o), 32'h0);
        check("mrst_after_bvalid", 32'(bvalid_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_write_resp_allocator.md
Name: axi_write_resp_allocator

Overview:
Per-target-port B-channel block of the AXI node, and the response-side counterpart of the AW address decoder. It arbitrates write responses from N_INIT_PORT initiator ports and from a local DECERR generator onto one slave-facing B channel. It also keeps the outstanding-write counter that the AW decoder uses to stall and to wait before issuing an error. The output is registered (one-entry response slice).

Parameters:
N_INIT_PORT, 8, number of initiator-side (slave-facing) ports returning B responses
AXI_ID_OUT, 6, width of BID on initiator side and on the output
MAX_OUTSTANDING, 8, maximum write transactions in flight through this target port
CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived, do not override)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
bvalid_i  in  N_INIT_PORT  per-port response valid
bid_i  in  N_INIT_PORT x AXI_ID_OUT  per-port response ID
bresp_i  in  N_INIT_PORT x 2  per-port response code
bready_o  out  N_INIT_PORT  per-port response accept
bvalid_o  out  1  registered response valid to master
bid_o  out  AXI_ID_OUT  registered response ID
bresp_o  out  2  registered response code
bready_i  in  1  master accepts response
error_req_i  in  1  AW decoder requests a DECERR response
error_id_i  in  AXI_ID_OUT  ID of the errored AW, already sampled by the AW side
error_gnt_o  out  1  DECERR response loaded this cycle
incr_req_i  in  1  one write forwarded to an initiator port this cycle
full_counter_o  out  1  counter == MAX_OUTSTANDING
outstanding_trans_o  out  1  counter != 0

Behaviour:
- Reset: bvalid_o=0, bid_o=0, bresp_o=0, counter=0, RR pointer=0, is_err flag=0. bready_o and error_gnt_o are combinational and are 0 while the slice is full and bready_i=0.
- Slice load condition: load = ~bvalid_o | bready_i. The slice accepts a new response in the same cycle the old one leaves, so full throughput is 1 response/cycle.
- Winner selection (combinational, only evaluated when load=1):
  - error_req_i has absolute priority.
  - Otherwise round-robin over bvalid_i, starting at the pointer.
- Error win:
  - error_gnt_o=1 and bready_o=0.
  - Next cycle: bvalid_o=1, bid_o=error_id_i, bresp_o=2'b11 (DECERR), is_err=1.
- Port k wins:
  - bready_o[k]=1 (one-hot; all other bits 0).
  - Next cycle: bvalid_o=1, bid_o=bid_i[k], bresp_o=bresp_i[k], is_err=0.
  - Pointer becomes (k+1) mod N_INIT_PORT.
- No winner and load=1: bvalid_o goes to 0 next cycle. Pointer is unchanged.
- Latency: 1 cycle from input handshake to bvalid_o.
- Stability: while bvalid_o=1 and bready_i=0, bid_o, bresp_o and bvalid_o are held and no input is accepted (AXI stability rule).
- Counter:
  - inc = incr_req_i.
  - dec = bvalid_o & bready_i & ~is_err. DECERR responses are never counted.
  - inc & dec in the same cycle: counter unchanged.
  - inc at MAX_OUTSTANDING: ignored (counter saturates). This is a protocol violation by the AW side; a simulation assertion fires.
  - dec at 0: ignored; assertion fires.
- Outstanding/full outputs: outstanding_trans_o and full_counter_o are decoded from the registered counter, so they update the cycle after the event.
- Error ordering: the AW decoder only raises error_req_i when outstanding_trans_o=0. The priority rule still guarantees a defined result if it coincides with late bvalid_i.
- Reset mid-operation: any held response is dropped and the counter is cleared. There is no recovery of lost responses.

Decomposition:
- Package axi_node_resp_pkg:
  - resp codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - b_payload_t struct {id, resp}, parameterised via localparam width.
- Sub-module axi_rr_arb_n:
  - N-input round-robin arbiter: req vector, enable (=load & ~error_req_i), one-hot gnt, registered pointer advancing on grant.
  - Reusable for the R channel.
- Counter and slice stay in the top module.

Test Plan:
- Single port: bvalid_i[2]=1, bid_i[2]=6'h05, bresp_i[2]=OKAY, bready_i=1 → bready_o=8'h04 same cycle; next cycle bvalid_o=1, bid_o=6'h05, bresp_o=2'b00.
- Round-robin: bvalid_i=8'h0B held with bready_i=1 → grants port 0, 1, 3, 0 on consecutive cycles; one response per cycle on the output.
- Backpressure: bready_i=0 for 5 cycles with bvalid_i[1]=1 → bready_o stays 0 and bid_o/bresp_o stable; on bready_i=1, port 1 is granted that cycle.
- Counter: 8 incr_req_i pulses → full_counter_o=1. One output B handshake together with an incr_req_i → count stays 8. Drain 8 responses → outstanding_trans_o=0.
- DECERR: counter=0, error_req_i=1, error_id_i=6'h2A → error_gnt_o=1; next cycle bresp_o=2'b11, bid_o=6'h2A. Handshake leaves the counter at 0 with no assertion.
- Reset mid-response: rst_n low while bvalid_o=1 and counter=3 → bvalid_o=0 and counter=0 immediately; after release, outstanding_trans_o=0.
